// File: rtl/rv32_exec_if.sv
// Decode/commit-side bundle for the RV32 execute core: control, operands and
// register/CSR results exchanged with the surrounding single-cycle datapath.
interface rv32_exec_if #(
  parameter int XLEN = 32
);
  logic [4:0]      rs1_addr;
  logic [4:0]      rs2_addr;
  logic [4:0]      rd_addr;
  logic            reg_wen;
  logic            wb_valid;
  logic [XLEN-1:0] rd_data;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] imm;
  logic [1:0]      src1_sel;
  logic [1:0]      src2_sel;
  logic [3:0]      alu_op;
  logic [2:0]      br_op;
  logic [11:0]     csr_addr;
  logic [2:0]      csr_op;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic [XLEN-1:0] alu_out;
  logic            branch_taken;
  logic [XLEN-1:0] csr_rdata;
  logic [XLEN-1:0] mtvec_out;
  logic [XLEN-1:0] mepc_out;

  modport master (
    output rs1_addr, rs2_addr, rd_addr, reg_wen, wb_valid, rd_data, pc, imm,
           src1_sel, src2_sel, alu_op, br_op, csr_addr, csr_op,
    input  rs1_data, rs2_data, alu_out, branch_taken, csr_rdata, mtvec_out, mepc_out
  );

  modport slave (
    input  rs1_addr, rs2_addr, rd_addr, reg_wen, wb_valid, rd_data, pc, imm,
           src1_sel, src2_sel, alu_op, br_op, csr_addr, csr_op,
    output rs1_data, rs2_data, alu_out, branch_taken, csr_rdata, mtvec_out, mepc_out
  );
endinterface

// File: rtl/rv32_exec_core.sv
// Execute/register stage of a single-cycle RV32 core: GPR file, operand muxes,
// ALU, branch comparator and the machine-mode CSRs mstatus/mtvec/mepc/mcause.
module rv32_exec_core #(
  parameter int              XLEN        = 32,
  parameter int              NREG        = 32,
  parameter logic [XLEN-1:0] MSTATUS_RST = 32'h0000_1800
) (
  input logic        clk,
  input logic        rst,
  rv32_exec_if.slave bus
);

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_AND   = 4'd2;
  localparam logic [3:0] ALU_OR    = 4'd3;
  localparam logic [3:0] ALU_XOR   = 4'd4;
  localparam logic [3:0] ALU_SLL   = 4'd5;
  localparam logic [3:0] ALU_SRL   = 4'd6;
  localparam logic [3:0] ALU_SRA   = 4'd7;
  localparam logic [3:0] ALU_SLT   = 4'd8;
  localparam logic [3:0] ALU_SLTU  = 4'd9;
  localparam logic [3:0] ALU_PASSB = 4'd10;

  localparam logic [2:0] BR_EQ  = 3'd1;
  localparam logic [2:0] BR_NE  = 3'd2;
  localparam logic [2:0] BR_LT  = 3'd3;
  localparam logic [2:0] BR_GE  = 3'd4;
  localparam logic [2:0] BR_LTU = 3'd5;
  localparam logic [2:0] BR_GEU = 3'd6;

  localparam logic [2:0] CSR_RW    = 3'd1;
  localparam logic [2:0] CSR_RS    = 3'd2;
  localparam logic [2:0] CSR_RC    = 3'd3;
  localparam logic [2:0] CSR_ECALL = 3'd4;

  localparam logic [11:0] ADDR_MSTATUS = 12'h300;
  localparam logic [11:0] ADDR_MTVEC   = 12'h305;
  localparam logic [11:0] ADDR_MEPC    = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE  = 12'h342;

  localparam logic [XLEN-1:0] CAUSE_ECALL_M = 32'd11;

  logic [XLEN-1:0] gpr_q [NREG];
  logic [XLEN-1:0] gpr_d [NREG];

  logic [XLEN-1:0] mstatus_q, mstatus_d;
  logic [XLEN-1:0] mtvec_q,   mtvec_d;
  logic [XLEN-1:0] mepc_q,    mepc_d;
  logic [XLEN-1:0] mcause_q,  mcause_d;

  logic [XLEN-1:0]        rs1_val, rs2_val, csr_rd, csr_wdata;
  logic [XLEN-1:0]        alu_a, alu_b, alu_res;
  logic signed [XLEN-1:0] alu_a_s, alu_b_s, rs1_s, rs2_s;
  logic [4:0]             shamt;
  logic                   br_res;

  // Register read: asynchronous, x0 forced to zero, no write bypass
  assign rs1_val = (bus.rs1_addr == 5'd0) ? '0 : gpr_q[bus.rs1_addr];
  assign rs2_val = (bus.rs2_addr == 5'd0) ? '0 : gpr_q[bus.rs2_addr];

  always_comb begin
    for (int i = 0; i < NREG; i++) gpr_d[i] = gpr_q[i];
    if (bus.wb_valid && bus.reg_wen && bus.rd_addr != 5'd0)
      gpr_d[bus.rd_addr] = bus.rd_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) gpr_q[i] <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) gpr_q[i] <= gpr_d[i];
    end
  end

  // Operand select and ALU
  always_comb begin
    case (bus.src1_sel)
      2'd0:    alu_a = rs1_val;
      2'd1:    alu_a = bus.pc;
      2'd2:    alu_a = '0;
      default: alu_a = csr_rd;
    endcase
    case (bus.src2_sel)
      2'd0:    alu_b = rs2_val;
      2'd1:    alu_b = bus.imm;
      2'd2:    alu_b = 32'd4;
      default: alu_b = rs1_val;
    endcase
  end

  assign alu_a_s = alu_a;
  assign alu_b_s = alu_b;
  assign shamt   = alu_b[4:0];

  always_comb begin
    alu_res = '0;
    case (bus.alu_op)
      ALU_ADD:   alu_res = alu_a + alu_b;
      ALU_SUB:   alu_res = alu_a - alu_b;
      ALU_AND:   alu_res = alu_a & alu_b;
      ALU_OR:    alu_res = alu_a | alu_b;
      ALU_XOR:   alu_res = alu_a ^ alu_b;
      ALU_SLL:   alu_res = alu_a << shamt;
      ALU_SRL:   alu_res = alu_a >> shamt;
      ALU_SRA:   alu_res = alu_a_s >>> shamt;
      ALU_SLT:   alu_res = {{(XLEN-1){1'b0}}, (alu_a_s < alu_b_s)};
      ALU_SLTU:  alu_res = {{(XLEN-1){1'b0}}, (alu_a < alu_b)};
      ALU_PASSB: alu_res = alu_b;
      default:   alu_res = '0;
    endcase
  end

  // Branch comparator always looks at the raw register operands
  assign rs1_s = rs1_val;
  assign rs2_s = rs2_val;

  always_comb begin
    br_res = 1'b0;
    case (bus.br_op)
      BR_EQ:   br_res = (rs1_val == rs2_val);
      BR_NE:   br_res = (rs1_val != rs2_val);
      BR_LT:   br_res = (rs1_s < rs2_s);
      BR_GE:   br_res = (rs1_s >= rs2_s);
      BR_LTU:  br_res = (rs1_val < rs2_val);
      BR_GEU:  br_res = (rs1_val >= rs2_val);
      default: br_res = 1'b0;
    endcase
  end

  // CSR read shows the pre-commit value; unimplemented addresses read zero
  always_comb begin
    case (bus.csr_addr)
      ADDR_MSTATUS: csr_rd = mstatus_q;
      ADDR_MTVEC:   csr_rd = mtvec_q;
      ADDR_MEPC:    csr_rd = mepc_q;
      ADDR_MCAUSE:  csr_rd = mcause_q;
      default:      csr_rd = '0;
    endcase
  end

  always_comb begin
    mstatus_d = mstatus_q;
    mtvec_d   = mtvec_q;
    mepc_d    = mepc_q;
    mcause_d  = mcause_q;
    case (bus.csr_op)
      CSR_RW:  csr_wdata = rs1_val;
      CSR_RS:  csr_wdata = csr_rd | rs1_val;
      CSR_RC:  csr_wdata = csr_rd & ~rs1_val;
      default: csr_wdata = csr_rd;
    endcase
    if (bus.wb_valid) begin
      if (bus.csr_op == CSR_RW || bus.csr_op == CSR_RS || bus.csr_op == CSR_RC) begin
        case (bus.csr_addr)
          ADDR_MSTATUS: mstatus_d = csr_wdata;
          ADDR_MTVEC:   mtvec_d   = csr_wdata;
          ADDR_MEPC:    mepc_d    = csr_wdata;
          ADDR_MCAUSE:  mcause_d  = csr_wdata;
          default:      ;
        endcase
      end else if (bus.csr_op == CSR_ECALL) begin
        mepc_d   = bus.pc;
        mcause_d = CAUSE_ECALL_M;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mstatus_q <= MSTATUS_RST;
      mtvec_q   <= '0;
      mepc_q    <= '0;
      mcause_q  <= '0;
    end else begin
      mstatus_q <= mstatus_d;
      mtvec_q   <= mtvec_d;
      mepc_q    <= mepc_d;
      mcause_q  <= mcause_d;
    end
  end

  assign bus.rs1_data     = rs1_val;
  assign bus.rs2_data     = rs2_val;
  assign bus.alu_out      = alu_res;
  assign bus.branch_taken = br_res;
  assign bus.csr_rdata    = csr_rd;
  assign bus.mtvec_out    = mtvec_q;
  assign bus.mepc_out     = mepc_q;

endmodule

// File: tb/tb_rv32_exec_core.sv
// Bench for rv32_exec_core: directed scenarios plus randomized commits, all
// checked against an architectural model of the GPRs and CSRs.
module tb_rv32_exec_core;

  logic clk = 1'b0;
  logic rst;

  rv32_exec_if bus ();

  rv32_exec_core dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] m_gpr [32];
  logic [31:0] m_mstatus, m_mtvec, m_mepc, m_mcause;

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_reg(input logic [4:0] a);
    return (a == 5'd0) ? 32'd0 : m_gpr[a];
  endfunction

  function automatic logic [31:0] m_csr(input logic [11:0] a);
    case (a)
      12'h300: return m_mstatus;
      12'h305: return m_mtvec;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic m_slt(input logic [31:0] a, input logic [31:0] b);
    return (a ^ 32'h8000_0000) < (b ^ 32'h8000_0000);
  endfunction

  function automatic logic [31:0] m_sra(input logic [31:0] a, input logic [4:0] s);
    logic [31:0] r;
    r = a >> s;
    if (a[31]) r = r | ~(32'hFFFF_FFFF >> s);
    return r;
  endfunction

  function automatic logic [31:0] m_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'd0:  return a + b;
      4'd1:  return a + ~b + 32'd1;
      4'd2:  return a & b;
      4'd3:  return a | b;
      4'd4:  return a ^ b;
      4'd5:  return a << b[4:0];
      4'd6:  return a >> b[4:0];
      4'd7:  return m_sra(a, b[4:0]);
      4'd8:  return {31'd0, m_slt(a, b)};
      4'd9:  return {31'd0, a < b};
      4'd10: return b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic m_br(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      3'd1: return a == b;
      3'd2: return a != b;
      3'd3: return m_slt(a, b);
      3'd4: return !m_slt(a, b);
      3'd5: return a < b;
      3'd6: return !(a < b);
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_gpr[i] = 32'd0;
    m_mstatus = 32'h0000_1800;
    m_mtvec   = 32'd0;
    m_mepc    = 32'd0;
    m_mcause  = 32'd0;
  endtask

  task automatic idle();
    bus.rs1_addr = 5'd0;  bus.rs2_addr = 5'd0;  bus.rd_addr = 5'd0;
    bus.reg_wen  = 1'b0;  bus.wb_valid = 1'b0;  bus.rd_data = 32'd0;
    bus.pc       = 32'd0; bus.imm      = 32'd0;
    bus.src1_sel = 2'd0;  bus.src2_sel = 2'd0;  bus.alu_op  = 4'd0;
    bus.br_op    = 3'd0;  bus.csr_addr = 12'd0; bus.csr_op  = 3'd0;
  endtask

  task automatic check_outputs();
    logic [31:0] r1, r2, a, b;
    #1;
    r1 = m_reg(bus.rs1_addr);
    r2 = m_reg(bus.rs2_addr);
    case (bus.src1_sel)
      2'd0: a = r1;
      2'd1: a = bus.pc;
      2'd2: a = 32'd0;
      default: a = m_csr(bus.csr_addr);
    endcase
    case (bus.src2_sel)
      2'd0: b = r2;
      2'd1: b = bus.imm;
      2'd2: b = 32'd4;
      default: b = r1;
    endcase
    check32("rs1_data", bus.rs1_data, r1);
    check32("rs2_data", bus.rs2_data, r2);
    check32("alu_out", bus.alu_out, m_alu(bus.alu_op, a, b));
    check32("branch_taken", {31'd0, bus.branch_taken}, {31'd0, m_br(bus.br_op, r1, r2)});
    check32("csr_rdata", bus.csr_rdata, m_csr(bus.csr_addr));
    check32("mtvec_out", bus.mtvec_out, m_mtvec);
    check32("mepc_out", bus.mepc_out, m_mepc);
  endtask

  task automatic model_commit();
    logic [31:0] r1, old, nv;
    if (!bus.wb_valid) return;
    r1  = m_reg(bus.rs1_addr);
    old = m_csr(bus.csr_addr);
    nv  = old;
    if (bus.csr_op == 3'd1) nv = r1;
    if (bus.csr_op == 3'd2) nv = old | r1;
    if (bus.csr_op == 3'd3) nv = old & ~r1;
    if (bus.csr_op >= 3'd1 && bus.csr_op <= 3'd3) begin
      case (bus.csr_addr)
        12'h300: m_mstatus = nv;
        12'h305: m_mtvec   = nv;
        12'h341: m_mepc    = nv;
        12'h342: m_mcause  = nv;
        default: ;
      endcase
    end else if (bus.csr_op == 3'd4) begin
      m_mepc   = bus.pc;
      m_mcause = 32'd11;
    end
    if (bus.reg_wen && bus.rd_addr != 5'd0) m_gpr[bus.rd_addr] = bus.rd_data;
  endtask

  // Check current combinational outputs, then let the commit edge happen
  task automatic cycle();
    check_outputs();
    model_commit();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_reg(input logic [4:0] rd, input logic [31:0] val);
    idle();
    bus.rd_addr = rd; bus.rd_data = val; bus.reg_wen = 1'b1; bus.wb_valid = 1'b1;
    cycle();
  endtask

  initial begin
    rst = 1'b1;
    idle();
    model_reset();
    #2;
    bus.csr_addr = 12'h300;
    bus.rs1_addr = 5'd3; bus.rs2_addr = 5'd31;
    check_outputs();
    check32("rst_mstatus", bus.csr_rdata, 32'h0000_1800);
    check32("rst_mtvec", bus.mtvec_out, 32'd0);
    #9 rst = 1'b0;
    @(posedge clk); #1;

    // x0 stays zero
    wr_reg(5'd0, 32'h0000_DEAD);
    idle(); #1;
    check32("x0_zero", bus.rs1_data, 32'd0);

    // Shifts and set-less-than
    wr_reg(5'd5, 32'h8000_0000);
    wr_reg(5'd6, 32'h0000_0001);
    idle();
    bus.rs1_addr = 5'd5; bus.src2_sel = 2'd1; bus.imm = 32'h21; bus.alu_op = 4'd7;
    #1 check32("sra", bus.alu_out, 32'hC000_0000);
    bus.alu_op = 4'd6;
    #1 check32("srl", bus.alu_out, 32'h4000_0000);
    bus.rs2_addr = 5'd6; bus.src2_sel = 2'd0; bus.alu_op = 4'd8;
    #1 check32("slt", bus.alu_out, 32'd1);
    bus.alu_op = 4'd9;
    #1 check32("sltu", bus.alu_out, 32'd0);
    cycle();

    // Branch comparator
    wr_reg(5'd7, 32'hFFFF_FFFF);
    wr_reg(5'd8, 32'h0000_0001);
    idle();
    bus.rs1_addr = 5'd7; bus.rs2_addr = 5'd8;
    bus.br_op = 3'd3; #1 check32("br_lt", {31'd0, bus.branch_taken}, 32'd1);
    bus.br_op = 3'd5; #1 check32("br_ltu", {31'd0, bus.branch_taken}, 32'd0);
    bus.br_op = 3'd6; #1 check32("br_geu", {31'd0, bus.branch_taken}, 32'd1);
    bus.rs1_addr = 5'd8;
    bus.br_op = 3'd1; #1 check32("br_eq", {31'd0, bus.branch_taken}, 32'd1);
    bus.br_op = 3'd2; #1 check32("br_ne", {31'd0, bus.branch_taken}, 32'd0);
    cycle();

    // PC + 4 and LUI-style pass-through
    idle();
    bus.pc = 32'h8000_0010; bus.src1_sel = 2'd1; bus.src2_sel = 2'd2; bus.alu_op = 4'd0;
    #1 check32("pc_plus4", bus.alu_out, 32'h8000_0014);
    bus.src2_sel = 2'd1; bus.imm = 32'h1234_5000; bus.alu_op = 4'd10;
    #1 check32("passb", bus.alu_out, 32'h1234_5000);
    cycle();

    // CSRRW mtvec, then ECALL
    wr_reg(5'd9, 32'h8000_0100);
    idle();
    bus.rs1_addr = 5'd9; bus.csr_addr = 12'h305; bus.csr_op = 3'd1; bus.wb_valid = 1'b1;
    #1 check32("csrrw_old", bus.csr_rdata, 32'd0);
    cycle();
    check32("mtvec_new", bus.mtvec_out, 32'h8000_0100);
    idle();
    bus.pc = 32'h8000_0040; bus.csr_op = 3'd4; bus.wb_valid = 1'b1; bus.csr_addr = 12'h342;
    cycle();
    idle(); bus.csr_addr = 12'h342; #1;
    check32("ecall_mepc", bus.mepc_out, 32'h8000_0040);
    check32("ecall_mcause", bus.csr_rdata, 32'd11);

    // wb_valid low freezes state
    for (int k = 0; k < 2; k++) begin
      idle();
      bus.reg_wen = 1'b1; bus.rd_addr = 5'd5; bus.rd_data = 32'h5555_0000 + k;
      bus.rs1_addr = 5'd9; bus.csr_addr = 12'h305; bus.csr_op = 3'd1;
      cycle();
    end
    idle(); bus.rs1_addr = 5'd5; bus.csr_addr = 12'h305; #1;
    check32("frozen_x5", bus.rs1_data, 32'h8000_0000);
    check32("frozen_mtvec", bus.mtvec_out, 32'h8000_0100);

    // Randomized commits
    for (int it = 0; it < 400; it++) begin
      bus.rs1_addr = 5'($urandom_range(0, 31));
      bus.rs2_addr = ($urandom_range(0, 3) == 0) ? bus.rs1_addr : 5'($urandom_range(0, 31));
      bus.rd_addr  = 5'($urandom_range(0, 31));
      bus.reg_wen  = 1'($urandom_range(0, 1));
      bus.wb_valid = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 3))
        0: bus.rd_data = 32'h8000_0000;
        1: bus.rd_data = 32'hFFFF_FFFF;
        default: bus.rd_data = $urandom;
      endcase
      bus.pc       = $urandom;
      bus.imm      = $urandom;
      bus.src1_sel = 2'($urandom_range(0, 3));
      bus.src2_sel = 2'($urandom_range(0, 3));
      bus.alu_op   = 4'($urandom_range(0, 15));
      bus.br_op    = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 4))
        0: bus.csr_addr = 12'h300;
        1: bus.csr_addr = 12'h305;
        2: bus.csr_addr = 12'h341;
        3: bus.csr_addr = 12'h342;
        default: bus.csr_addr = 12'($urandom);
      endcase
      bus.csr_op   = 3'($urandom_range(0, 7));
      cycle();
    end

    // Asynchronous reset mid-cycle with writes pending
    wr_reg(5'd12, 32'hCAFE_F00D);
    idle();
    bus.rs1_addr = 5'd12; bus.rd_addr = 5'd12; bus.rd_data = 32'h1111_2222;
    bus.reg_wen = 1'b1; bus.wb_valid = 1'b1; bus.csr_addr = 12'h300; bus.csr_op = 3'd1;
    #2 rst = 1'b1;
    model_reset();
    #1;
    check32("arst_x12", bus.rs1_data, 32'd0);
    check32("arst_mstatus", bus.csr_rdata, 32'h0000_1800);
    check_outputs();
    rst = 1'b0;
    idle();
    @(posedge clk); #1;
    bus.rs1_addr = 5'd12;
    check_outputs();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
